// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
// Self-checking stimulus/response block for a two-input gate primitive set.
// A one-cycle start request launches a run. Each run sweeps the a/b truth
// table (00, 01, 10, 11) LOOPS times. After every vector has settled for
// SETTLE_CYCLES, the seven gate outputs are compared against their expected
// values.
//
// Parameters:
//   SETTLE_CYCLES : cycles between driving a vector and sampling (1..15)
//   LOOPS         : full 4-vector sweeps per run (1..255)
//   ERR_W         : width of the saturating error counter
//
// Ports:
//   clk                          rising-edge clock
//   rst                          synchronous active-high reset
//   start                        run request, only honoured in IDLE
//   a_out / b_out                drive gate inputs a (vector bit 1) / b (bit 0)
//   yand..yxnor                  gate outputs under test
//   busy                         run in progress
//   done                         one-cycle pulse at end of run
//   pass                         last completed run had no mismatching vector
//   err_count                    mismatching vectors, saturating at all-ones
//   fail_mask                    sticky per-output mismatch flags
//                                (bit0 yand ... bit6 yxnor)
//
// Optional feature (macro GATE_CHK_ERRLOG_EN):
//   first_fail_valid/_vec/_loop/_mask capture the first mismatching check
//   of a run. They are cleared on an accepted start and on rst.
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             yand,
  input  logic             ynand,
  input  logic             yor,
  input  logic             ynor,
  input  logic             ynot,
  input  logic             yxor,
  input  logic             yxnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask
`ifdef GATE_CHK_ERRLOG_EN
  ,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [7:0]       first_fail_loop,
  output logic [6:0]       first_fail_mask
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_t     state_r;
  logic [1:0] vector_r;
  logic [7:0] loop_r;
  logic [3:0] settle_r;

  logic [6:0] observed_s;
  logic [6:0] expected_s;
  logic [6:0] mismatch_s;
  logic       any_mismatch_s;

  // Reference truth table for one vector; bit order matches fail_mask.
  function automatic logic [6:0] expected_outputs(input logic [1:0] vec);
    logic a;
    logic b;
    a = vec[1];
    b = vec[0];
    return {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
  endfunction

  assign observed_s = {yxnor, yxor, ynot, ynor, yor, ynand, yand};

  // Per-output mismatch.
  // Case inequality makes X/Z on a gate output count as a failure.
  always_comb begin
    mismatch_s = 7'd0;
    expected_s = expected_outputs(vector_r);
    for (int i = 0; i < 7; i++) begin
      mismatch_s[i] = (observed_s[i] !== expected_s[i]);
    end
    any_mismatch_s = |mismatch_s;
  end

  // Run sequencer: vector/loop/settle bookkeeping, result accumulation
  // and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      vector_r  <= 2'd0;
      loop_r    <= 8'd0;
      settle_r  <= 4'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= 7'd0;
`ifdef GATE_CHK_ERRLOG_EN
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 2'd0;
      first_fail_loop  <= 8'd0;
      first_fail_mask  <= 7'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= SETTLE;
            vector_r  <= 2'd0;
            loop_r    <= 8'd0;
            settle_r  <= 4'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= 7'd0;
`ifdef GATE_CHK_ERRLOG_EN
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'd0;
            first_fail_loop  <= 8'd0;
            first_fail_mask  <= 7'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SETTLE: begin
          if (settle_r == SETTLE_LAST) begin
            settle_r <= 4'd0;
            state_r  <= CHECK;
          end else begin
            settle_r <= settle_r + 4'd1;
          end
        end
        CHECK: begin
          fail_mask <= fail_mask | mismatch_s;
          if (any_mismatch_s && (err_count != ERR_MAX)) begin
            err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
          end else begin
            err_count <= err_count;
          end
`ifdef GATE_CHK_ERRLOG_EN
          if (any_mismatch_s && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= vector_r;
            first_fail_loop  <= loop_r;
            first_fail_mask  <= mismatch_s;
          end else begin
            first_fail_valid <= first_fail_valid;
          end
`endif
          if (vector_r != 2'd3) begin
            vector_r         <= vector_r + 2'd1;
            {a_out, b_out}   <= vector_r + 2'd1;
            state_r          <= SETTLE;
          end else if (loop_r < LOOP_LAST) begin
            loop_r   <= loop_r + 8'd1;
            vector_r <= 2'd0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            state_r  <= SETTLE;
          end else begin
            state_r <= DONE;
          end
        end
        DONE: begin
          // The pulse and final verdict appear on the edge leaving DONE.
          done    <= 1'b1;
          busy    <= 1'b0;
          pass    <= (err_count == '0);
          a_out   <= 1'b0;
          b_out   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [3];
  logic       start_v [3];
  logic       a_v     [3];
  logic       b_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [6:0] mask_v  [3];
  logic [7:0] err_v   [3];
  int         mode_v  [3];

  logic [7:0] err0;
  logic [7:0] err1;
  logic [1:0] err2;
  logic [6:0] g0;
  logic [6:0] g1;
  logic [6:0] g2;

  assign err_v[0] = err0;
  assign err_v[1] = err1;
  assign err_v[2] = {6'd0, err2};

`ifdef GATE_CHK_ERRLOG_EN
  logic       ffv_v    [3];
  logic [1:0] ffvec_v  [3];
  logic [7:0] ffloop_v [3];
  logic [6:0] ffmask_v [3];
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Gate block model with injectable faults.
  // Modes:
  //   0 golden
  //   1 yxor stuck-at-0
  //   2 ynot = a
  //   3 all outputs inverted
  //   4 yand driven X
  function automatic logic [6:0] gate_model(input logic a, input logic b, input int mode);
    logic [6:0] y;
    y = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
    case (mode)
      1:       y[5] = 1'b0;
      2:       y[4] = a;
      3:       y = ~y;
      4:       y[0] = 1'bx;
      default: y = y;
    endcase
    return y;
  endfunction

  assign g0 = gate_model(a_v[0], b_v[0], mode_v[0]);
  assign g1 = gate_model(a_v[1], b_v[1], mode_v[1]);
  assign g2 = gate_model(a_v[2], b_v[2], mode_v[2]);

  gate_truth_table_checker #(.SETTLE_CYCLES(S), .LOOPS(1), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
    .yand(g0[0]), .ynand(g0[1]), .yor(g0[2]), .ynor(g0[3]), .ynot(g0[4]),
    .yxor(g0[5]), .yxnor(g0[6]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err0), .fail_mask(mask_v[0])
`ifdef GATE_CHK_ERRLOG_EN
    , .first_fail_valid(ffv_v[0]), .first_fail_vec(ffvec_v[0]),
    .first_fail_loop(ffloop_v[0]), .first_fail_mask(ffmask_v[0])
`endif
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(S), .LOOPS(3), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
    .yand(g1[0]), .ynand(g1[1]), .yor(g1[2]), .ynor(g1[3]), .ynot(g1[4]),
    .yxor(g1[5]), .yxnor(g1[6]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err1), .fail_mask(mask_v[1])
`ifdef GATE_CHK_ERRLOG_EN
    , .first_fail_valid(ffv_v[1]), .first_fail_vec(ffvec_v[1]),
    .first_fail_loop(ffloop_v[1]), .first_fail_mask(ffmask_v[1])
`endif
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(S), .LOOPS(2), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
    .yand(g2[0]), .ynand(g2[1]), .yor(g2[2]), .ynor(g2[3]), .ynot(g2[4]),
    .yxor(g2[5]), .yxnor(g2[6]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err2), .fail_mask(mask_v[2])
`ifdef GATE_CHK_ERRLOG_EN
    , .first_fail_valid(ffv_v[2]), .first_fail_vec(ffvec_v[2]),
    .first_fail_loop(ffloop_v[2]), .first_fail_mask(ffmask_v[2])
`endif
  );

  typedef struct {
    int         err;
    logic [6:0] mask;
    logic       pass;
    int         lat;
    logic       ffv;
    logic [1:0] fvec;
    logic [7:0] floop;
    logic [6:0] fmask;
  } exp_t;

  exp_t sb[$];

  // Push the expected outcome of one run onto the scoreboard.
  task automatic predict(input int mode, input int loops, input int errw);
    exp_t       e;
    int         maxe;
    logic [1:0] vb;
    logic [6:0] ref_y;
    logic [6:0] got;
    logic [6:0] mm;
    e.err = 0; e.mask = 7'd0; e.ffv = 1'b0; e.fvec = 2'd0; e.floop = 8'd0; e.fmask = 7'd0;
    maxe = (1 << errw) - 1;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 4; v++) begin
        vb    = 2'(v);
        ref_y = gate_model(vb[1], vb[0], 0);
        got   = gate_model(vb[1], vb[0], mode);
        for (int i = 0; i < 7; i++) mm[i] = (got[i] !== ref_y[i]);
        if (mm != 7'd0) begin
          e.mask = e.mask | mm;
          if (e.err < maxe) e.err++;
          if (!e.ffv) begin
            e.ffv = 1'b1; e.fvec = vb; e.floop = 8'(l); e.fmask = mm;
          end
        end
      end
    end
    e.pass = (e.err == 0);
    e.lat  = 4 * loops * (S + 1) + 1;
    sb.push_back(e);
  endtask

  // Start a run on instance u and follow the a/b sequence until done.
  // Then pop the scoreboard and compare the final results.
  task automatic run_and_check(input int u, input string name, input int loops, input int repulse);
    exp_t       e;
    int         k;
    int         nv;
    logic [1:0] ev;
    nv = 4 * loops * (S + 1);
    @(negedge clk); start_v[u] = 1'b1;
    @(negedge clk); start_v[u] = 1'b0; k = 0;
    while (done_v[u] !== 1'b1 && k < 300) begin
      if (k < nv) begin
        ev = 2'((k / (S + 1)) % 4);
        n_vec++;
        if ({a_v[u], b_v[u]} !== ev || busy_v[u] !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_seq k=%0d: ab=%b busy=%b, expected ab=%b busy=1",
                   name, k, {a_v[u], b_v[u]}, busy_v[u], ev);
        end
      end
      start_v[u] = (k == repulse);
      @(negedge clk); k++;
    end
    start_v[u] = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (done_v[u] !== 1'b1 || k != e.lat) begin
      n_fail++;
      $display("FAIL %s_latency: done=%b at %0d edges, expected 1 at %0d", name, done_v[u], k, e.lat);
    end
    n_vec++;
    if (err_v[u] !== 8'(e.err) || mask_v[u] !== e.mask || pass_v[u] !== e.pass) begin
      n_fail++;
      $display("FAIL %s_result: err=%0d mask=%b pass=%b, expected err=%0d mask=%b pass=%b",
               name, err_v[u], mask_v[u], pass_v[u], e.err, e.mask, e.pass);
    end
    n_vec++;
    if (busy_v[u] !== 1'b0 || {a_v[u], b_v[u]} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b ab=%b, expected 0 00", name, busy_v[u], {a_v[u], b_v[u]});
    end
`ifdef GATE_CHK_ERRLOG_EN
    n_vec++;
    if (ffv_v[u] !== e.ffv || ffvec_v[u] !== e.fvec || ffloop_v[u] !== e.floop || ffmask_v[u] !== e.fmask) begin
      n_fail++;
      $display("FAIL %s_errlog: v=%b vec=%b loop=%0d mask=%b, expected v=%b vec=%b loop=%0d mask=%b",
               name, ffv_v[u], ffvec_v[u], ffloop_v[u], ffmask_v[u], e.ffv, e.fvec, e.floop, e.fmask);
    end
`endif
    @(negedge clk);
    n_vec++;
    if (done_v[u] !== 1'b0 || err_v[u] !== 8'(e.err) || mask_v[u] !== e.mask) begin
      n_fail++;
      $display("FAIL %s_hold: done=%b err=%0d mask=%b, expected done=0 err=%0d mask=%b",
               name, done_v[u], err_v[u], mask_v[u], e.err, e.mask);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      rst_v[u] = 1'b1; start_v[u] = 1'b0; mode_v[u] = 0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      n_vec++;
      if ({a_v[u], b_v[u], busy_v[u], done_v[u], pass_v[u]} !== 5'd0 ||
          err_v[u] !== 8'd0 || mask_v[u] !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_u%0d: ab=%b busy=%b done=%b pass=%b err=%0d mask=%b, expected all 0",
                 u, {a_v[u], b_v[u]}, busy_v[u], done_v[u], pass_v[u], err_v[u], mask_v[u]);
      end
`ifdef GATE_CHK_ERRLOG_EN
      n_vec++;
      if (ffv_v[u] !== 1'b0 || ffmask_v[u] !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_errlog_u%0d: v=%b mask=%b, expected 0", u, ffv_v[u], ffmask_v[u]);
      end
`endif
      rst_v[u] = 1'b0;
    end
  endtask

  task automatic test_golden();
    mode_v[0] = 0; predict(0, 1, 8); run_and_check(0, "golden", 1, -1);
  endtask

  task automatic test_back_to_back();
    mode_v[0] = 0; predict(0, 1, 8); run_and_check(0, "restart_ignored", 1, 5);
    predict(0, 1, 8); run_and_check(0, "back_to_back", 1, -1);
  endtask

  task automatic test_xor_stuck();
    mode_v[0] = 1; predict(1, 1, 8); run_and_check(0, "xor_stuck0", 1, -1);
  endtask

  task automatic test_ynot_loops();
    mode_v[1] = 2; predict(2, 3, 8); run_and_check(1, "ynot_loops3", 3, -1);
  endtask

  task automatic test_saturate();
    mode_v[2] = 3; predict(3, 2, 2); run_and_check(2, "saturate", 2, -1);
  endtask

  task automatic test_x_input();
    mode_v[0] = 4; predict(4, 1, 8); run_and_check(0, "yand_x", 1, -1);
  endtask

  task automatic test_midrun_reset();
    int saw_done;
    mode_v[0] = 3;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk); rst_v[0] = 1'b0;
    n_vec++;
    if ({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0]} !== 5'd0 ||
        err_v[0] !== 8'd0 || mask_v[0] !== 7'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: ab=%b busy=%b done=%b pass=%b err=%0d mask=%b, expected all 0",
               {a_v[0], b_v[0]}, busy_v[0], done_v[0], pass_v[0], err_v[0], mask_v[0]);
    end
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) saw_done = 1;
    end
    n_vec++;
    if (saw_done != 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: activity=%0d after reset, expected 0", saw_done);
    end
    mode_v[0] = 0; predict(0, 1, 8); run_and_check(0, "after_reset", 1, -1);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_back_to_back();
    test_xor_stuck();
    test_ynot_loops();
    test_saturate();
    test_x_input();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Self-checking stimulus/response block for the two-input gate-level primitive set.
- Drives the a/b inputs of a gate block through the full truth table (00, 01, 10, 11) and samples its seven outputs.
- Compares the outputs against expected values, then accumulates an error count and a sticky per-output fail mask.
- Used as the on-chip/bench consumer of the gate block's outputs; runs are started by a one-cycle start request and signalled complete by a done pulse.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling outputs; legal range 1..15.
- LOOPS, 1, number of full 4-vector sweeps per run; legal range 1..255.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- a_out  output  1  drives gate block input a (vector bit 1).
- b_out  output  1  drives gate block input b (vector bit 0).
- yand, ynand, yor, ynor, ynot, yxor, yxnor  input  1 each  gate block outputs under test.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  high when the last completed run had err_count==0; held until next accepted start.
- err_count  output  ERR_W  vectors with any mismatch, saturating at all-ones.
- fail_mask  output  7  sticky OR of per-output mismatches; bit0=yand, bit1=ynand, bit2=yor, bit3=ynor, bit4=ynot, bit5=yxor, bit6=yxnor.

Behaviour:
- Reset values: a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state=IDLE, vector=0, loop=0, settle counter=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 at edge T -> state SETTLE, vector=0, loop=0, a_out/b_out=00, err_count=0, fail_mask=0, pass=0, busy=1. start=0 -> remain IDLE.
- SETTLE: held for exactly SETTLE_CYCLES cycles, then CHECK.
- CHECK: lasts one cycle. Outputs are compared with a=vector[1], b=vector[0]. Expected values:
  - yand=a&b, ynand=~(a&b)
  - yor=a|b, ynor=~(a|b)
  - ynot=~a
  - yxor=a^b, yxnor=~(a^b)
- Comparison is case-inequality: X or Z on any input counts as a mismatch.
- At the end of the CHECK cycle:
  - fail_mask |= mismatch vector.
  - If any mismatch, err_count += 1, saturating (no wrap).
- Next state after CHECK:
  - vector<3: vector+1, new a_out/b_out, state SETTLE.
  - vector==3 and loop<LOOPS-1: loop+1, vector=0, state SETTLE.
  - Otherwise: state DONE.
- DONE: lasts one cycle. done=1, busy=0, pass=(err_count==0), a_out/b_out=00, then IDLE.
- Latency: done is high in the cycle starting 4*LOOPS*(SETTLE_CYCLES+1)+1 edges after edge T. Defaults give 13.
- a_out/b_out change only on SETTLE entry; they are stable through SETTLE and CHECK.
- start while busy or in DONE: ignored, with no restart and no queueing.
- rst asserted in any state: all registers return to reset values on that edge, with no done pulse. rst has priority over start.
- err_count and fail_mask hold their final values after done until the next accepted start.

Optional Feature:
- Macro GATE_CHK_ERRLOG_EN.
- Defined: adds outputs first_fail_valid (1), first_fail_vec (2), first_fail_loop (8) and first_fail_mask (7).
  - These capture the first mismatching CHECK of a run.
  - They are cleared on accepted start and on rst, and are never overwritten until the next start.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Golden gate block, defaults, start pulse -> a_out/b_out sequence 00,01,10,11, each held 3 cycles; done at edge 13; pass=1, err_count=0, fail_mask=0.
- yxor stuck-at-0 -> mismatches at vectors 01 and 10; err_count=2, fail_mask=7'b0100000, pass=0. With GATE_CHK_ERRLOG_EN: first_fail_vec=01, first_fail_loop=0, first_fail_mask=7'b0100000.
- ynot driven as a (inverted), LOOPS=3 -> err_count=12, fail_mask=7'b0010000, done at edge 4*3*3+1=37.
- ERR_W=2, all seven outputs inverted, LOOPS=2 -> err_count saturates at 3, fail_mask=7'h7F.
- start re-pulsed mid-run at cycle 5 -> ignored, done still at edge 13. rst asserted at cycle 6 -> all outputs zero next edge, no done. A new start then runs cleanly to pass=1.
- yand driven X -> counted as mismatch: err_count=4, fail_mask bit0=1.
